pixel_readout_capture: RTL and testbench
========================================

PIXEL_READOUT_CAPTURE -- requirements
Module: pixel_readout_capture

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter CONVST_CYCLES, default 2, adc_convst high width in clocks (at least 1).
REQ-003 SHALL have parameter CONV_TIMEOUT, default 255, maximum clocks spent waiting for adc_busy low.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-005 SHALL have frame_busy in 1: frame in progress, from the timing generator.
REQ-006 SHALL have adc_start_trigger in 1: single-cycle request to convert the current pixel.
REQ-007 SHALL have row_addr in 12 and col_addr in 12: pixel address, valid with the trigger.
REQ-008 SHALL have col_end in 12: last column of the readout window.
REQ-009 SHALL have adc_convst out 1: ADC convert-start strobe.
REQ-010 SHALL have adc_busy in 1: ADC converting; adc_data is valid when this falls.
REQ-011 SHALL have adc_data in 16: ADC result.
REQ-012 SHALL have the pixel stream outputs pix_valid out 1, pix_ready in 1, pix_data out 16, pix_row out 12, pix_col out 12, pix_sof out 1, pix_eol out 1.
REQ-013 SHALL have clear_err in 1: clears the sticky flags.
REQ-014 SHALL have sticky flags trig_miss out 1, overflow out 1 and timeout_err out 1.

Function
REQ-015 SHALL implement the FSM IDLE -> CONVST -> CONV -> CAPTURE -> IDLE.
REQ-016 SHALL, in IDLE, on adc_start_trigger, latch row_addr and col_addr and enter CONVST on the next clock.
REQ-017 SHALL hold adc_convst high for exactly CONVST_CYCLES clocks while in CONVST, then enter CONV.
REQ-018 SHALL, in CONV, enter CAPTURE on the first clock adc_busy is sampled low, no earlier than 1 clock after CONV entry.
REQ-019 SHALL, if CONV lasts CONV_TIMEOUT clocks without that condition, enter CAPTURE with data forced to 16'hFFFF and set timeout_err.
REQ-020 SHALL, in CAPTURE (one clock), push {data, row, col, sof, eol} into the FIFO, where eol = (latched col == col_end).
REQ-021 SHALL set sof on the first capture after each frame_busy rising edge and clear it for all later captures in that frame.
REQ-022 SHALL ignore adc_start_trigger outside IDLE and set trig_miss.
REQ-023 SHALL drop the sample and set overflow when the FIFO is full at CAPTURE; FIFO contents are unchanged.
REQ-024 SHALL transfer the FIFO head on pix_valid and pix_ready; the head is stable while pix_valid is high and pix_ready is low.
REQ-025 SHALL give first-word latency of 1 clock from CAPTURE to pix_valid.
REQ-026 SHALL handle push and pop in the same clock, including with the FIFO full; when full, the pop frees space first so no overflow occurs.
REQ-027 SHALL clear all sticky flags on clear_err, with a same-clock set winning over clear.
REQ-028 SHALL, when frame_busy falls mid-conversion, finish the conversion normally; it is not aborted.

Reset
REQ-029 SHALL, on rst_n low, put the FSM in IDLE, empty the FIFO and zero all counters.
REQ-030 SHALL drive every output low during reset: adc_convst, pix_valid, pix_sof, pix_eol, trig_miss, overflow, timeout_err, and zero pix_data, pix_row and pix_col.
REQ-031 SHALL discard an in-flight conversion on reset, with adc_convst low immediately because reset is asynchronous.

Configuration
REQ-032 SHALL, with READOUT_DARK_SUB_EN defined, add input dark_offset (16) and produce pushed data = adc_data - dark_offset, saturated at 0.
REQ-033 SHALL leave the timeout value 16'hFFFF unsubtracted when READOUT_DARK_SUB_EN is defined.
REQ-034 SHALL, without READOUT_DARK_SUB_EN, have no dark_offset port and push raw data.

Structure
REQ-035 SHALL place the FSM state enum, the 16'hFFFF timeout code and the FIFO entry struct (data, row, col, sof, eol) in package readout_pkg.
REQ-036 SHALL implement the FIFO as the sub-module readout_fifo, parameterised on depth and entry type, with full and empty outputs.

Verification
REQ-037 SHALL cover: single trigger at row 3, col 5, col_end 5, adc_busy high 4 clocks, adc_data 16'h1234 -> one beat 16'h1234, row 3, col 5, sof 1, eol 1.
REQ-038 SHALL cover: adc_busy held high 300 clocks -> capture after 255 clocks in CONV, data 16'hFFFF, timeout_err 1.
REQ-039 SHALL cover: second trigger during CONV -> trig_miss 1, exactly one beat output.
REQ-040 SHALL cover: pix_ready low, 9 conversions -> 8 beats retained, overflow 1; release pix_ready -> beats 0 to 7 in order.
REQ-041 SHALL cover: full FIFO with push and pop in the same clock -> no overflow, count stays 8.
REQ-042 SHALL cover: with READOUT_DARK_SUB_EN, dark_offset 16'h0100 -> adc_data 16'h0180 outputs 16'h0080; adc_data 16'h0050 outputs 16'h0000; rst_n low mid-CONVST -> adc_convst drops asynchronously, no beat output.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types for the pixel readout capture block: FSM states, the timeout
// data code, the FIFO entry layout and the dark-offset subtraction helper.
package readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVST  = 2'd1,
        ST_CONV    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_CODE = 16'hFFFF;

    typedef struct packed {
        logic [15:0] data;
        logic [11:0] row;
        logic [11:0] col;
        logic        sof;
        logic        eol;
    } pix_entry_t;

    // Unsigned subtraction clamped at zero.
    function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? (a - b) : 16'd0;
    endfunction

endpackage

// File: rtl/pixel_readout_capture_if.sv
// Pixel stream valid/ready bus: master produces beats, slave consumes them.
interface pixel_readout_capture_if;
    logic        valid;
    logic        ready;
    logic [15:0] data;
    logic [11:0] row;
    logic [11:0] col;
    logic        sof;
    logic        eol;

    modport master (output valid, data, row, col, sof, eol, input ready);
    modport slave  (input valid, data, row, col, sof, eol, output ready);
endinterface

// File: rtl/readout_fifo.sv
// Synchronous FIFO of generic entries; a pop in the same clock frees space
// for a push, so a full FIFO can accept a push while it is being drained.
module readout_fifo
    import readout_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = pix_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head reads as zero when empty so the stream outputs are clean in reset.
    assign head = empty ? entry_t'('0) : mem[rd_ptr_reg];

endmodule

// File: rtl/pixel_readout_capture.sv
// Pixel ADC readout: trigger -> convert-start strobe -> wait busy -> capture
// into an output FIFO. Define READOUT_DARK_SUB_EN to add dark_offset subtraction.
module pixel_readout_capture
    import readout_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_busy,
    input  logic        adc_start_trigger,
    input  logic [11:0] row_addr,
    input  logic [11:0] col_addr,
    input  logic [11:0] col_end,
    output logic        adc_convst,
    input  logic        adc_busy,
    input  logic [15:0] adc_data,
`ifdef READOUT_DARK_SUB_EN
    input  logic [15:0] dark_offset,
`endif
    input  logic        clear_err,
    output logic        trig_miss,
    output logic        overflow,
    output logic        timeout_err,
    pixel_readout_capture_if.master pix
);
    localparam logic [15:0] CONVST_LAST = 16'(CONVST_CYCLES - 1);
    localparam logic [15:0] CONV_LAST   = 16'(CONV_TIMEOUT - 1);

    state_t      state_reg;
    logic [15:0] cnt_reg;
    logic [11:0] row_reg;
    logic [11:0] col_reg;
    logic [15:0] data_reg;
    logic        convst_reg;
    logic        frame_busy_d_reg;
    logic        sof_pending_reg;
    logic        trig_miss_reg;
    logic        overflow_reg;
    logic        timeout_err_reg;

    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        capture;
    logic        frame_rise;
    logic        busy_done;
    logic        timeout_hit;
    logic [15:0] conv_data;
    pix_entry_t  push_entry;
    pix_entry_t  head;

`ifdef READOUT_DARK_SUB_EN
    assign conv_data = sat_sub(adc_data, dark_offset);
`else
    assign conv_data = adc_data;
`endif

    // Busy is ignored on the first CONV clock; the ADC may not have raised it yet.
    assign busy_done   = (state_reg == ST_CONV) && (cnt_reg != 16'd0) && !adc_busy;
    assign timeout_hit = (state_reg == ST_CONV) && !busy_done && (cnt_reg == CONV_LAST);
    assign capture     = (state_reg == ST_CAPTURE);
    assign frame_rise  = frame_busy && !frame_busy_d_reg;
    assign pop         = pix.valid && pix.ready;

    always_comb begin
        push_entry      = '0;
        push_entry.data = data_reg;
        push_entry.row  = row_reg;
        push_entry.col  = col_reg;
        push_entry.sof  = sof_pending_reg || frame_rise;
        push_entry.eol  = (col_reg == col_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            row_reg    <= '0;
            col_reg    <= '0;
            data_reg   <= '0;
            convst_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (adc_start_trigger) begin
                        row_reg    <= row_addr;
                        col_reg    <= col_addr;
                        cnt_reg    <= '0;
                        convst_reg <= 1'b1;
                        state_reg  <= ST_CONVST;
                    end
                end
                ST_CONVST: begin
                    if (cnt_reg == CONVST_LAST) begin
                        cnt_reg    <= '0;
                        convst_reg <= 1'b0;
                        state_reg  <= ST_CONV;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_CONV: begin
                    if (busy_done) begin
                        data_reg  <= conv_data;
                        state_reg <= ST_CAPTURE;
                    end else if (timeout_hit) begin
                        data_reg  <= TIMEOUT_CODE;
                        state_reg <= ST_CAPTURE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_CAPTURE: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Sticky flags: a set in the same clock as clear_err wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_busy_d_reg <= 1'b0;
            sof_pending_reg  <= 1'b0;
            trig_miss_reg    <= 1'b0;
            overflow_reg     <= 1'b0;
            timeout_err_reg  <= 1'b0;
        end else begin
            frame_busy_d_reg <= frame_busy;
            if (capture) begin
                sof_pending_reg <= 1'b0;
            end else if (frame_rise) begin
                sof_pending_reg <= 1'b1;
            end
            trig_miss_reg   <= (trig_miss_reg & ~clear_err)
                             | (adc_start_trigger && (state_reg != ST_IDLE));
            overflow_reg    <= (overflow_reg & ~clear_err) | (capture && fifo_full && !pop);
            timeout_err_reg <= (timeout_err_reg & ~clear_err) | timeout_hit;
        end
    end

    readout_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (pix_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign adc_convst  = convst_reg;
    assign trig_miss   = trig_miss_reg;
    assign overflow    = overflow_reg;
    assign timeout_err = timeout_err_reg;

    assign pix.valid = !fifo_empty;
    assign pix.data  = head.data;
    assign pix.row   = head.row;
    assign pix.col   = head.col;
    assign pix.sof   = head.sof;
    assign pix.eol   = head.eol;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Directed bench for pixel_readout_capture with a queue-based beat model and a
// per-cycle compare of the stream head. Dark-offset cases need READOUT_DARK_SUB_EN.
module tb_pixel_readout_capture;
    import readout_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 255;

    typedef struct packed {
        logic [15:0] data;
        logic [11:0] row;
        logic [11:0] col;
        logic        sof;
        logic        eol;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_busy = 1'b0;
    logic        trig = 1'b0;
    logic [11:0] row_addr = '0;
    logic [11:0] col_addr = '0;
    logic [11:0] col_end = '0;
    logic        adc_busy = 1'b0;
    logic [15:0] adc_data = '0;
    logic [15:0] dark_offset = '0;
    logic        clear_err = 1'b0;
    logic        adc_convst;
    logic        trig_miss;
    logic        overflow;
    logic        timeout_err;

    pixel_readout_capture_if pix_bus ();

    always #5 clk = ~clk;

    pixel_readout_capture #(
        .FIFO_DEPTH    (DEPTH),
        .CONVST_CYCLES (2),
        .CONV_TIMEOUT  (TMO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frame_busy        (frame_busy),
        .adc_start_trigger (trig),
        .row_addr          (row_addr),
        .col_addr          (col_addr),
        .col_end           (col_end),
        .adc_convst        (adc_convst),
        .adc_busy          (adc_busy),
        .adc_data          (adc_data),
`ifdef READOUT_DARK_SUB_EN
        .dark_offset       (dark_offset),
`endif
        .clear_err         (clear_err),
        .trig_miss         (trig_miss),
        .overflow          (overflow),
        .timeout_err       (timeout_err),
        .pix               (pix_bus)
    );

    beat_t model_q[$];
    beat_t last_beat = '0;
    beat_t exp_b;
    int    n_cmp = 0;
    int    n_fail = 0;
    int    beats = 0;
    bit    sof_pending = 1'b0;
    bit    exp_ovf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected beat of one capture, from the functional rules alone.
    task automatic model_capture(input logic [11:0] row, input logic [11:0] col,
                                 input logic [15:0] data, input bit timed_out);
        beat_t b;
        b.data = data;
`ifdef READOUT_DARK_SUB_EN
        b.data = (data > dark_offset) ? data - dark_offset : 16'd0;
`endif
        if (timed_out) b.data = 16'hFFFF;
        b.row = row;
        b.col = col;
        b.sof = sof_pending;
        b.eol = (col == col_end);
        sof_pending = 1'b0;
        if (model_q.size() >= DEPTH && !pix_bus.ready) exp_ovf = 1'b1;
        else model_q.push_back(b);
    endtask

    // k counts clocks after the edge that samples the trigger (k=0).
    task automatic convert(input logic [11:0] row, input logic [11:0] col,
                           input logic [15:0] data, input int n,
                           input bit extra_trig, input bit chk_lat, input bit ready_pulse);
        int cap_k;
        int last_k;
        step(); row_addr = row; col_addr = col; trig = 1'b1;
        step(); trig = 1'b0; chk("convst_k0", adc_convst, 1);
        step(); chk("convst_k1", adc_convst, 1);
        step(); chk("convst_k2", adc_convst, 0); adc_busy = 1'b1;
        cap_k  = (n <= TMO - 1) ? n + 3 : TMO + 2;
        last_k = ((n + 2 > cap_k) ? n + 2 : cap_k) + 1;
        for (int k = 3; k <= last_k; k++) begin
            step();
            if (extra_trig && k == 3) begin trig = 1'b1; clear_err = 1'b1; end
            if (extra_trig && k == 4) begin trig = 1'b0; clear_err = 1'b0; end
            if (k == n + 2) begin adc_busy = 1'b0; adc_data = data; end
            if (k == cap_k) begin
                if (ready_pulse) pix_bus.ready = 1'b1;
                model_capture(row, col, data, n > TMO - 1);
                if (chk_lat) chk("lat_capture_cycle", pix_bus.valid, 0);
            end
            if (k == cap_k + 1) begin
                if (chk_lat) chk("lat_first_word", pix_bus.valid, 1);
                if (ready_pulse) pix_bus.ready = 1'b0;
            end
        end
    endtask

    task automatic frame_start();
        step(); frame_busy = 1'b0;
        step(); frame_busy = 1'b1; sof_pending = 1'b1;
        step();
    endtask

    // Head must match the model front on every valid cycle; a handshake retires it.
    always @(negedge clk) begin
        beat_t got;
        if (rst_n && pix_bus.valid) begin
            got = '{data: pix_bus.data, row: pix_bus.row, col: pix_bus.col,
                    sof: pix_bus.sof, eol: pix_bus.eol};
            if (model_q.size() == 0) begin
                chk("unexpected_beat", pix_bus.valid, 0);
            end else begin
                chk("beat_head", got, model_q[0]);
                if (pix_bus.ready) begin
                    void'(model_q.pop_front());
                    beats++;
                    last_beat = got;
                    $display("beat %0d: data=%h row=%0d col=%0d sof=%0b eol=%0b",
                             beats, got.data, got.row, got.col, got.sof, got.eol);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_bus.ready = 1'b0;
        repeat (3) step();
        chk("reset_outputs", {adc_convst, pix_bus.valid, pix_bus.sof, pix_bus.eol, trig_miss,
                              overflow, timeout_err, pix_bus.data, pix_bus.row, pix_bus.col}, 0);
        step(); rst_n = 1'b1;
        col_end = 12'd5;
        pix_bus.ready = 1'b1;

        // Single conversion, first of the frame, last column.
        frame_start();
        convert(12'd3, 12'd5, 16'h1234, 4, 1'b0, 1'b1, 1'b0);
        repeat (3) step();
        exp_b = '{data: 16'h1234, row: 12'd3, col: 12'd5, sof: 1'b1, eol: 1'b1};
        chk("single_beat", last_beat, exp_b);
        chk("single_count", beats, 1);

        // Busy stuck high: timeout after 255 CONV clocks.
        convert(12'd4, 12'd6, 16'hABCD, 300, 1'b0, 1'b1, 1'b0);
        repeat (3) step();
        exp_b = '{data: 16'hFFFF, row: 12'd4, col: 12'd6, sof: 1'b0, eol: 1'b0};
        chk("timeout_beat", last_beat, exp_b);
        chk("timeout_err_set", timeout_err, 1);

        // Trigger during CONV, with clear_err in the same clock.
        convert(12'd7, 12'd2, 16'h0777, 4, 1'b1, 1'b0, 1'b0);
        repeat (5) step();
        chk("trig_miss_set", trig_miss, 1);
        chk("timeout_err_cleared", timeout_err, 0);
        chk("trig_miss_one_beat", beats, 3);
        clear_err = 1'b1; step(); clear_err = 1'b0; step();
        chk("trig_miss_cleared", trig_miss, 0);

        // Nine conversions into a stalled 8-deep FIFO.
        frame_start();
        pix_bus.ready = 1'b0;
        for (int i = 0; i < 9; i++) convert(12'd1, 12'(i), 16'(i), 2, 1'b0, 1'b0, 1'b0);
        chk("overflow_set", overflow, 1);
        chk("overflow_model", overflow, exp_ovf);
        chk("overflow_head", pix_bus.data, 16'd0);
        pix_bus.ready = 1'b1;
        repeat (12) step();
        chk("overflow_drain_count", beats, 11);
        chk("overflow_last_data", last_beat.data, 16'd7);
        chk("overflow_drained", pix_bus.valid, 0);

        // Full FIFO with push and pop in the same clock.
        clear_err = 1'b1; step(); clear_err = 1'b0; step();
        chk("overflow_cleared", overflow, 0);
        pix_bus.ready = 1'b0;
        for (int i = 10; i < 18; i++) convert(12'd2, 12'(i), 16'(i), 2, 1'b0, 1'b0, 1'b0);
        convert(12'd2, 12'd18, 16'd18, 2, 1'b0, 1'b0, 1'b1);
        step();
        chk("full_pushpop_no_overflow", overflow, 0);
        chk("full_pushpop_one_pop", beats, 12);
        pix_bus.ready = 1'b1;
        repeat (12) step();
        chk("full_pushpop_count8", beats, 20);
        chk("full_pushpop_last", last_beat.data, 16'd18);

`ifdef READOUT_DARK_SUB_EN
        dark_offset = 16'h0100;
        convert(12'd2, 12'd1, 16'h0180, 3, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        chk("dark_sub", last_beat.data, 16'h0080);
        convert(12'd2, 12'd2, 16'h0050, 3, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        chk("dark_sat", last_beat.data, 16'h0000);
`endif

        // Reset asserted mid-CONVST drops the strobe at once and loses the sample.
        begin
            int beats_before;
            beats_before = beats;
            step(); row_addr = 12'd9; col_addr = 12'd9; trig = 1'b1;
            step(); trig = 1'b0;
            chk("rst_convst_before", adc_convst, 1);
            #2 rst_n = 1'b0;
            #1 chk("rst_convst_async", adc_convst, 0);
            chk("rst_stream_idle", {pix_bus.valid, pix_bus.data, trig_miss, overflow, timeout_err}, 0);
            step(); step(); rst_n = 1'b1;
            repeat (20) step();
            chk("rst_no_beat", beats, beats_before);
            chk("rst_valid_low", pix_bus.valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
